// File: rtl/ysyx_23060025_icache.sv
// rtl/ysyx_23060025_icache.sv - direct-mapped read-only instruction cache with burst line refill
module ysyx_23060025_icache #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ifu_psel_i,
  input  logic [ADDR_WIDTH-1:0] ifu_paddr_i,
  output logic                  ifu_pready_o,
  output logic [DATA_WIDTH-1:0] ifu_prdata_o,
  input  logic                  fencei_i,
  output logic                  mem_arvalid_o,
  output logic [ADDR_WIDTH-1:0] mem_araddr_o,
  output logic [7:0]            mem_arlen_o,
  input  logic                  mem_arready_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_rlast_i,
  output logic                  mem_rready_o,
  output logic [31:0]           hit_cnt_o,
  output logic [31:0]           miss_cnt_o
);
  localparam int OFF   = $clog2(LINE_WORDS * 4);
  localparam int IDX   = $clog2(SETS);
  localparam int TAG_W = ADDR_WIDTH - IDX - OFF;
  localparam int WB    = $clog2(LINE_WORDS);

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_MISS_AR, S_MISS_R, S_RESP} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   req_addr_q, req_addr_d;
  logic [SETS-1:0]         valid_q, valid_d;
  logic [TAG_W-1:0]        tag_q [SETS];
  logic [TAG_W-1:0]        tag_d [SETS];
  logic [DATA_WIDTH-1:0]   data_q [SETS][LINE_WORDS];
  logic [DATA_WIDTH-1:0]   data_d [SETS][LINE_WORDS];
  logic [WB-1:0]           beat_q, beat_d;
  logic [DATA_WIDTH-1:0]   resp_q, resp_d;
  logic                    pend_q, pend_d;
  logic [31:0]             hit_cnt_q, hit_cnt_d;
  logic [31:0]             miss_cnt_q, miss_cnt_d;

  logic [WB-1:0]           req_word;
  logic [IDX-1:0]          req_idx;
  logic [TAG_W-1:0]        req_tag;
  logic                    lookup_hit;
  logic                    unused_addr_bits;

  assign req_word   = req_addr_q[OFF-1:2];
  assign req_idx    = req_addr_q[OFF+IDX-1:OFF];
  assign req_tag    = req_addr_q[ADDR_WIDTH-1:OFF+IDX];
  assign lookup_hit = (state_q == S_LOOKUP) && valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign unused_addr_bits = ^req_addr_q[1:0];

  // The hit response is combinational so back-to-back hits sustain one fetch per cycle.
  assign ifu_pready_o  = lookup_hit || (state_q == S_RESP);
  assign ifu_prdata_o  = (state_q == S_RESP) ? resp_q :
                         (lookup_hit ? data_q[req_idx][req_word] : '0);
  assign mem_arvalid_o = (state_q == S_MISS_AR);
  assign mem_araddr_o  = mem_arvalid_o ? {req_tag, req_idx, {OFF{1'b0}}} : '0;
  assign mem_arlen_o   = mem_arvalid_o ? 8'(LINE_WORDS - 1) : 8'd0;
  assign mem_rready_o  = (state_q == S_MISS_R);
  assign hit_cnt_o     = hit_cnt_q;
  assign miss_cnt_o    = miss_cnt_q;

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    valid_d    = valid_q;
    tag_d      = tag_q;
    data_d     = data_q;
    beat_d     = beat_q;
    resp_d     = resp_q;
    pend_d     = pend_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (fencei_i) valid_d = '0;
        if (ifu_psel_i) begin
          req_addr_d = ifu_paddr_i;
          state_d    = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (fencei_i) valid_d = '0;
        if (lookup_hit) begin
          hit_cnt_d = hit_cnt_q + 32'd1;
          if (ifu_psel_i) req_addr_d = ifu_paddr_i;
          else            state_d    = S_IDLE;
        end else begin
          miss_cnt_d = miss_cnt_q + 32'd1;
          state_d    = S_MISS_AR;
        end
      end
      S_MISS_AR: begin
        if (fencei_i) pend_d = 1'b1;
        if (mem_arready_i) begin
          beat_d  = '0;
          state_d = S_MISS_R;
        end
      end
      S_MISS_R: begin
        if (fencei_i) pend_d = 1'b1;
        if (mem_rvalid_i) begin
          data_d[req_idx][beat_q] = mem_rdata_i;
          if (beat_q == req_word) resp_d = mem_rdata_i;
          beat_d = beat_q + 1'b1;
          if (mem_rlast_i) begin
            tag_d[req_idx] = req_tag;
            // A fence seen during the refill leaves the new line unusable.
            if (!(pend_q || fencei_i)) valid_d[req_idx] = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (pend_q || fencei_i) valid_d = '0;
        pend_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      req_addr_q <= '0;
      valid_q    <= '0;
      beat_q     <= '0;
      resp_q     <= '0;
      pend_q     <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      valid_q    <= valid_d;
      beat_q     <= beat_d;
      resp_q     <= resp_d;
      pend_q     <= pend_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end
endmodule

// File: tb/tb_ysyx_23060025_icache.sv
// tb/tb_ysyx_23060025_icache.sv - directed scoreboard bench for the instruction cache
module tb_ysyx_23060025_icache;
  logic        clock = 1'b0;
  logic        reset;
  logic        ifu_psel_i;
  logic [31:0] ifu_paddr_i;
  logic        ifu_pready_o;
  logic [31:0] ifu_prdata_o;
  logic        fencei_i;
  logic        mem_arvalid_o;
  logic [31:0] mem_araddr_o;
  logic [7:0]  mem_arlen_o;
  logic        mem_arready_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        mem_rlast_i;
  logic        mem_rready_o;
  logic [31:0] hit_cnt_o;
  logic [31:0] miss_cnt_o;

  int          n_chk = 0;
  int          n_fail = 0;
  int          hit_exp = 0;
  int          miss_exp = 0;
  logic [31:0] exp_q[$];

  always #5 clock = ~clock;

  ysyx_23060025_icache dut (
    .clock(clock), .reset(reset),
    .ifu_psel_i(ifu_psel_i), .ifu_paddr_i(ifu_paddr_i),
    .ifu_pready_o(ifu_pready_o), .ifu_prdata_o(ifu_prdata_o),
    .fencei_i(fencei_i),
    .mem_arvalid_o(mem_arvalid_o), .mem_araddr_o(mem_araddr_o), .mem_arlen_o(mem_arlen_o),
    .mem_arready_i(mem_arready_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .mem_rlast_i(mem_rlast_i), .mem_rready_o(mem_rready_o),
    .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
  );

  // Backing memory: the line at 0x8000_0000 holds 0x11..0x44, everything else is address-derived.
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    logic [31:0] la;
    la = {a[31:2], 2'b00};
    if (la[31:4] == 28'h8000000) return 32'h11 * (32'(la[3:2]) + 32'd1);
    return {la[15:0], ~la[15:0]};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $error("FAIL %s: observed %h expected <none queued>", tag, ifu_prdata_o);
    end else begin
      e = exp_q.pop_front();
      chk(tag, ifu_prdata_o, e);
    end
  endtask

  task automatic chk_cnt();
    chk("hit_cnt", hit_cnt_o, 32'(hit_exp));
    chk("miss_cnt", miss_cnt_o, 32'(miss_exp));
  endtask

  task automatic fetch(input logic [31:0] addr, input bit exp_hit, input int ar_stall,
                       input bit gaps, input bit fence_mid);
    logic [31:0] line;
    line = {addr[31:4], 4'h0};
    exp_q.push_back(mem_rd(addr));
    ifu_psel_i  = 1'b1;
    ifu_paddr_i = addr;
    tick();
    ifu_psel_i  = 1'b0;
    ifu_paddr_i = $urandom;
    #1;
    if (exp_hit) begin
      chk("hit_pready", 32'(ifu_pready_o), 32'd1);
      chk("hit_arvalid", 32'(mem_arvalid_o), 32'd0);
      pop_chk("hit_prdata");
      hit_exp++;
      tick();
    end else begin
      chk("miss_pready", 32'(ifu_pready_o), 32'd0);
      miss_exp++;
      tick();
      #1;
      for (int s = 0; s < ar_stall; s++) begin
        chk("stall_arvalid", 32'(mem_arvalid_o), 32'd1);
        chk("stall_araddr", mem_araddr_o, line);
        tick();
        #1;
      end
      mem_arready_i = 1'b1;
      chk("arvalid", 32'(mem_arvalid_o), 32'd1);
      chk("araddr", mem_araddr_o, line);
      chk("arlen", 32'(mem_arlen_o), 32'd3);
      tick();
      mem_arready_i = 1'b0;
      for (int b = 0; b < 4; b++) begin
        if (gaps) begin
          #1;
          chk("gap_rready", 32'(mem_rready_o), 32'd1);
          chk("gap_pready", 32'(ifu_pready_o), 32'd0);
          tick();
        end
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = mem_rd(line + 32'(b * 4));
        mem_rlast_i  = (b == 3);
        if (fence_mid && b == 1) fencei_i = 1'b1;
        #1;
        chk("beat_rready", 32'(mem_rready_o), 32'd1);
        chk("beat_pready", 32'(ifu_pready_o), 32'd0);
        tick();
        mem_rvalid_i = 1'b0;
        mem_rlast_i  = 1'b0;
        fencei_i     = 1'b0;
        mem_rdata_i  = $urandom;
      end
      #1;
      chk("resp_pready", 32'(ifu_pready_o), 32'd1);
      pop_chk("resp_prdata");
      tick();
    end
    #1;
    chk_cnt();
  endtask

  initial begin
    reset = 1'b1;
    ifu_psel_i = 1'b0; ifu_paddr_i = '0; fencei_i = 1'b0;
    mem_arready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0; mem_rlast_i = 1'b0;
    tick(); tick();
    #1;
    chk("rst_pready", 32'(ifu_pready_o), 32'd0);
    chk("rst_prdata", ifu_prdata_o, 32'd0);
    chk("rst_arvalid", 32'(mem_arvalid_o), 32'd0);
    chk("rst_araddr", mem_araddr_o, 32'd0);
    chk("rst_arlen", 32'(mem_arlen_o), 32'd0);
    chk("rst_rready", 32'(mem_rready_o), 32'd0);
    chk_cnt();
    reset = 1'b0;
    tick();

    // Cold miss, then hits including a back-to-back pair.
    fetch(32'h8000_0004, 1'b0, 0, 1'b0, 1'b0);
    exp_q.push_back(32'h44);
    exp_q.push_back(32'h11);
    ifu_psel_i = 1'b1; ifu_paddr_i = 32'h8000_000C;
    tick();
    ifu_paddr_i = 32'h8000_0000;
    #1;
    chk("b2b_pready0", 32'(ifu_pready_o), 32'd1);
    chk("b2b_arvalid", 32'(mem_arvalid_o), 32'd0);
    pop_chk("b2b_prdata0");
    tick();
    ifu_psel_i = 1'b0;
    #1;
    chk("b2b_pready1", 32'(ifu_pready_o), 32'd1);
    pop_chk("b2b_prdata1");
    tick();
    hit_exp += 2;
    #1;
    chk_cnt();

    // Conflict on index 0.
    fetch(32'h8000_0100, 1'b0, 0, 1'b0, 1'b0);
    fetch(32'h8000_0004, 1'b0, 0, 1'b0, 1'b0);
    fetch(32'h8000_0008, 1'b1, 0, 1'b0, 1'b0);

    // fence.i while idle, and during a refill.
    fencei_i = 1'b1;
    tick();
    fencei_i = 1'b0;
    fetch(32'h8000_0004, 1'b0, 0, 1'b0, 1'b0);
    fetch(32'h8000_0204, 1'b0, 0, 1'b0, 1'b1);
    fetch(32'h8000_0204, 1'b0, 0, 1'b0, 1'b0);
    fetch(32'h8000_0208, 1'b1, 0, 1'b0, 1'b0);

    // Address-channel stall and gaps between beats; last word of a line.
    fetch(32'h8000_004C, 1'b0, 5, 1'b1, 1'b0);
    fetch(32'h8000_0040, 1'b1, 0, 1'b0, 1'b0);

    // Reset in the middle of the data burst.
    ifu_psel_i = 1'b1; ifu_paddr_i = 32'h8000_0084;
    tick();
    ifu_psel_i = 1'b0;
    tick();
    mem_arready_i = 1'b1;
    tick();
    mem_arready_i = 1'b0;
    for (int b = 0; b < 2; b++) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = mem_rd(32'h8000_0080 + 32'(b * 4));
      tick();
    end
    mem_rdata_i = mem_rd(32'h8000_0088);
    reset = 1'b1;
    tick();
    mem_rvalid_i = 1'b0;
    reset = 1'b0;
    hit_exp = 0;
    miss_exp = 0;
    #1;
    chk("rst_mid_rready", 32'(mem_rready_o), 32'd0);
    chk("rst_mid_pready", 32'(ifu_pready_o), 32'd0);
    chk_cnt();
    fetch(32'h8000_0084, 1'b0, 0, 1'b0, 1'b0);
    fetch(32'h8000_008C, 1'b1, 0, 1'b0, 1'b0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
